uart_apb_regfile: RTL and testbench

//  APB slave register file for the UART, parametrised successor of the fixed 8-bit UART register top.

---
 rtl/uart_apb_regfile.sv | 219 +++++++++++++++++++++
 tb/tb_uart_apb_regfile.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_apb_regfile.sv
// APB register file for the UART core: TX/RX FIFOs, status, control, baud divisor, sticky errors, irq.
// Optional TX->RX loopback path is compiled in when UART_LOOPBACK_EN is defined.

module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [W-1:0]              i_wdata,
   output logic [W-1:0]              o_rdata,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_full,
   output logic                      o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = DEPTH[AW:0];

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == L_FULL);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   // a full FIFO still takes a push when the head leaves on the same edge
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end
endmodule

module uart_apb_regfile #(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int ADDR_W      = 8,
   parameter int DEFAULT_DIV = 651
) (
   input  logic              pClk,
   input  logic              pReset,
   input  logic              pSel,
   input  logic              pEnable,
   input  logic              pWrite,
   input  logic [ADDR_W-1:0] pAddr,
   input  logic [31:0]       pWdata,
   output logic [31:0]       pReadData,
   output logic              pReady,
   output logic              pSlvErr,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_err,
   output logic [15:0]       baud_div,
   output logic              irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] L_DIV = 16'(DEFAULT_DIV);

   logic        r_tx_en, r_rx_en, r_irq_rx_en, r_irq_tx_en;
   logic        r_rx_ovr, r_rx_ferr, r_irq;
   logic [15:0] r_baud;

   logic              w_access, w_wr, w_rd, w_loop;
   logic [2:0]        w_idx;
   logic              w_data_wr, w_data_rd, w_stat_wr, w_ctrl_wr, w_baud_wr;
   logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [AW:0]       w_tx_count, w_rx_count;
   logic [DATA_W-1:0] w_tx_head, w_rx_head, w_rx_wdata;
   logic              w_tx_valid, w_tx_rdy, w_tx_pop, w_tx_push, w_tx_flush;
   logic              w_rx_push_req, w_rx_push, w_rx_pop, w_rx_flush;
   logic              w_ovr_set, w_ferr_set, w_tx_drop;
   logic [31:0]       w_rd_data;
   logic              w_err;
   logic              w_unused;

   assign w_access  = pSel & pEnable;
   assign w_wr      = w_access & pWrite;
   assign w_rd      = w_access & ~pWrite;
   assign w_idx     = pAddr[4:2];
   assign w_data_wr = w_wr & (w_idx == 3'd0);
   assign w_data_rd = w_rd & (w_idx == 3'd0);
   assign w_stat_wr = w_wr & (w_idx == 3'd1);
   assign w_ctrl_wr = w_wr & (w_idx == 3'd2);
   assign w_baud_wr = w_wr & (w_idx == 3'd3);

`ifdef UART_LOOPBACK_EN
   logic r_loop;
   always_ff @(posedge pClk) begin
      if (pReset)         r_loop <= 1'b0;
      else if (w_ctrl_wr) r_loop <= pWdata[6];
   end
   assign w_loop = r_loop;
`else
   assign w_loop = 1'b0;
`endif

   // TX side: in loopback the core is bypassed and the head drains every cycle
   assign w_tx_valid = r_tx_en & ~w_tx_empty;
   assign w_tx_rdy   = w_loop | tx_ready;
   assign w_tx_pop   = w_tx_valid & w_tx_rdy;
   assign w_tx_drop  = w_tx_full & ~w_tx_pop;
   assign w_tx_push  = w_data_wr & ~w_tx_drop;
   assign w_tx_flush = w_ctrl_wr & pWdata[4];
   assign tx_valid   = w_tx_valid & ~w_loop;
   assign tx_data    = w_tx_head;

   uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk   (pClk),
      .i_rst   (pReset),
      .i_flush (w_tx_flush),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_wdata (pWdata[DATA_W-1:0]),
      .o_rdata (w_tx_head),
      .o_count (w_tx_count),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   assign w_rx_push_req = r_rx_en & (w_loop ? w_tx_pop : rx_valid);
   assign w_rx_wdata    = w_loop ? w_tx_head : rx_data;
   assign w_rx_pop      = w_data_rd & ~w_rx_empty;
   assign w_rx_push     = w_rx_push_req;
   assign w_rx_flush    = w_ctrl_wr & pWdata[5];
   assign w_ovr_set     = w_rx_push_req & w_rx_full & ~w_rx_pop;
   assign w_ferr_set    = rx_err & ~w_loop;

   uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk   (pClk),
      .i_rst   (pReset),
      .i_flush (w_rx_flush),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_wdata (w_rx_wdata),
      .o_rdata (w_rx_head),
      .o_count (w_rx_count),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   always_ff @(posedge pClk) begin
      if (pReset) begin
         r_tx_en     <= 1'b0;
         r_rx_en     <= 1'b0;
         r_irq_rx_en <= 1'b0;
         r_irq_tx_en <= 1'b0;
         r_baud      <= L_DIV;
         r_rx_ovr    <= 1'b0;
         r_rx_ferr   <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_tx_en     <= pWdata[0];
            r_rx_en     <= pWdata[1];
            r_irq_rx_en <= pWdata[2];
            r_irq_tx_en <= pWdata[3];
         end
         if (w_baud_wr) r_baud <= pWdata[15:0];
         // a new error on the clearing edge must not be lost
         r_rx_ovr  <= w_ovr_set  | (r_rx_ovr  & ~(w_stat_wr & pWdata[4]));
         r_rx_ferr <= w_ferr_set | (r_rx_ferr & ~(w_stat_wr & pWdata[5]));
         r_irq     <= (r_irq_rx_en & ~w_rx_empty) | (r_irq_tx_en & w_tx_empty)
                    | r_rx_ovr | r_rx_ferr;
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_err     = 1'b0;
      if (w_access) begin
         case (w_idx)
            3'd0: begin
               if (!pWrite && !w_rx_empty) w_rd_data = 32'(w_rx_head);
               w_err = pWrite ? w_tx_drop : w_rx_empty;
            end
            3'd1: w_rd_data = {8'h00, 8'(w_rx_count), 8'(w_tx_count), 2'b00, r_rx_ferr,
                               r_rx_ovr, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            3'd2: w_rd_data = {25'd0, w_loop, 2'b00, r_irq_tx_en, r_irq_rx_en, r_rx_en, r_tx_en};
            3'd3: w_rd_data = {16'h0000, r_baud};
            default: w_err = 1'b1;
         endcase
         if (pWrite) w_rd_data = '0;
      end
   end

   assign pReadData = w_rd_data;
   assign pSlvErr   = w_err;
   assign pReady    = 1'b1;
   assign baud_div  = r_baud;
   assign irq       = r_irq;
   assign w_unused  = ^{pAddr[ADDR_W-1:5], pAddr[1:0], pWdata[31:16]};
endmodule

// File: tb/tb_uart_apb_regfile.sv
// Directed bench for uart_apb_regfile: APB accesses, FIFO boundaries, sticky flags, irq timing, reset.
module tb_uart_apb_regfile;
   logic        pClk, pReset, pSel, pEnable, pWrite;
   logic [7:0]  pAddr;
   logic [31:0] pWdata, pReadData;
   logic        pReady, pSlvErr;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_err, irq;
   logic [15:0] baud_div;

   int          n_chk = 0;
   int          n_pass = 0;
   logic        err;
   logic [31:0] rd;

   uart_apb_regfile dut (
      .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
      .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData), .pReady(pReady),
      .pSlvErr(pSlvErr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .baud_div(baud_div), .irq(irq)
   );

   initial pClk = 1'b0;
   always #5 pClk = ~pClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge pClk); #1;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
      pSel = 1; pEnable = 0; pWrite = 1; pAddr = a; pWdata = d;
      tick(); pEnable = 1;
      @(negedge pClk); e = pSlvErr;
      tick(); pSel = 0; pEnable = 0; pWrite = 0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      pSel = 1; pEnable = 0; pWrite = 0; pAddr = a; pWdata = '0;
      tick(); pEnable = 1;
      @(negedge pClk); d = pReadData; e = pSlvErr;
      tick(); pSel = 0; pEnable = 0;
   endtask

   initial begin
      pReset = 1; pSel = 0; pEnable = 0; pWrite = 0; pAddr = '0; pWdata = '0;
      tx_ready = 0; rx_data = '0; rx_valid = 0; rx_err = 0;
      tick(); tick(); pReset = 0;

      // reset state
      chk("rst_idle_rdata", pReadData, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_pready", {31'd0, pReady}, 32'd1);
      apb_read(8'h04, rd, err); chk("rst_stat", rd, 32'h0000_000A); chk("rst_stat_err", {31'd0, err}, 32'd0);
      apb_read(8'h08, rd, err); chk("rst_ctrl", rd, 32'h0);
      apb_read(8'h0C, rd, err); chk("rst_baud", rd, 32'd651);
      chk("rst_baud_div", {16'd0, baud_div}, 32'd651);
      apb_write(8'h08, 32'h0000_004F, err);
      apb_read(8'h08, rd, err);
`ifdef UART_LOOPBACK_EN
      chk("ctrl_rw", rd, 32'h0000_004F);
`else
      chk("ctrl_rw", rd, 32'h0000_000F);
`endif
      apb_write(8'h08, 32'h0, err);

      // TX drain in order
      apb_write(8'h08, 32'h1, err);
      apb_write(8'h00, 32'h41, err); chk("tx_wr_err", {31'd0, err}, 32'd0);
      chk("tx_valid_1", {31'd0, tx_valid}, 32'd1);
      chk("tx_head_41", {24'd0, tx_data}, 32'h41);
      apb_write(8'h00, 32'h42, err);
      chk("tx_hold_41", {24'd0, tx_data}, 32'h41);
      tx_ready = 1;
      tick(); chk("tx_head_42", {24'd0, tx_data}, 32'h42); chk("tx_valid_2", {31'd0, tx_valid}, 32'd1);
      tick(); chk("tx_valid_0", {31'd0, tx_valid}, 32'd0);
      tx_ready = 0;
      apb_read(8'h04, rd, err); chk("tx_stat_empty", rd, 32'h0000_000A);

      // TX full boundary
      apb_write(8'h08, 32'h0, err);
      for (int i = 0; i < 17; i++) begin
         apb_write(8'h00, 32'(i), err);
         if (i == 15) chk("tx16_err", {31'd0, err}, 32'd0);
         if (i == 16) chk("tx17_err", {31'd0, err}, 32'd1);
      end
      apb_read(8'h04, rd, err); chk("tx_full_stat", rd, 32'h0000_1009);
      apb_write(8'h08, 32'h10, err);
      apb_read(8'h08, rd, err); chk("ctrl_flush_rd0", rd, 32'h0);
      apb_read(8'h04, rd, err); chk("tx_flush_stat", rd, 32'h0000_000A);

      // RX fill and overflow
      apb_write(8'h08, 32'h2, err);
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'(i); rx_valid = 1; tick();
      end
      rx_valid = 0;
      apb_read(8'h04, rd, err); chk("rx_ovr_stat", rd, 32'h0010_0016);
      chk("rx_ovr_irq", {31'd0, irq}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         apb_read(8'h00, rd, err);
         chk($sformatf("rx_rd%0d", i), rd, 32'(i));
         if (i == 0) chk("rx_rd_err", {31'd0, err}, 32'd0);
      end
      apb_read(8'h00, rd, err);
      chk("rx_empty_err", {31'd0, err}, 32'd1);
      chk("rx_empty_data", rd, 32'h0);

      // irq timing and sticky W1C
      apb_write(8'h04, 32'h30, err); tick();
      chk("irq_clr_ovr", {31'd0, irq}, 32'd0);
      apb_write(8'h08, 32'h6, err); tick();
      rx_data = 8'h77; rx_valid = 1; tick(); rx_valid = 0;
      chk("irq_lat0", {31'd0, irq}, 32'd0);
      tick(); chk("irq_lat1", {31'd0, irq}, 32'd1);
      apb_read(8'h00, rd, err); chk("irq_rx_data", rd, 32'h77);
      tick(); chk("irq_after_pop", {31'd0, irq}, 32'd0);
      rx_err = 1; tick(); rx_err = 0; tick();
      chk("irq_ferr", {31'd0, irq}, 32'd1);
      apb_read(8'h04, rd, err); chk("ferr_stat", rd, 32'h0000_002A);
      apb_write(8'h04, 32'h30, err); tick();
      chk("irq_ferr_clr", {31'd0, irq}, 32'd0);
      apb_read(8'h04, rd, err); chk("ferr_clr_stat", rd, 32'h0000_000A);
      pSel = 1; pWrite = 1; pAddr = 8'h04; pWdata = 32'h30; tick();
      pEnable = 1; rx_err = 1; tick();
      pSel = 0; pEnable = 0; pWrite = 0; rx_err = 0;
      apb_read(8'h04, rd, err); chk("set_wins_stat", rd, 32'h0000_002A);
      apb_write(8'h04, 32'h30, err);

      // decode, baud and mid-access reset
      apb_read(8'h10, rd, err); chk("unmap_err", {31'd0, err}, 32'd1); chk("unmap_data", rd, 32'h0);
      apb_write(8'h1C, 32'h1, err); chk("unmap_wr_err", {31'd0, err}, 32'd1);
      apb_write(8'h0C, 32'hFFFF_1234, err);
      apb_read(8'h0C, rd, err); chk("baud_rd", rd, 32'h0000_1234);
      chk("baud_div", {16'd0, baud_div}, 32'h1234);
      pSel = 1; pWrite = 1; pAddr = 8'h0C; pWdata = 32'h5555; tick();
      pEnable = 1; pReset = 1; tick();
      pSel = 0; pEnable = 0; pWrite = 0; pReset = 0;
      apb_read(8'h0C, rd, err); chk("rst_mid_baud", rd, 32'd651);
      apb_read(8'h08, rd, err); chk("rst_mid_ctrl", rd, 32'h0);

`ifdef UART_LOOPBACK_EN
      apb_write(8'h08, 32'h43, err);
      apb_write(8'h00, 32'h5A, err);
      chk("lb_tx_valid", {31'd0, tx_valid}, 32'd0);
      tick();
      chk("lb_tx_valid2", {31'd0, tx_valid}, 32'd0);
      apb_read(8'h00, rd, err); chk("lb_rx_data", rd, 32'h5A); chk("lb_rx_err", {31'd0, err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
